// File: rtl/eth_dma_sched.sv
// Round-robin scheduler sharing one iDMA backend between TX and RX frame descriptors.
// Issues one request per frame, bounds in-flight transfers and reports in-order completions.
module eth_dma_sched #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned TFLenWidth     = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    en_i,
  input  logic                                    tx_desc_valid_i,
  output logic                                    tx_desc_ready_o,
  input  logic [AddrWidth-1:0]                    tx_desc_addr_i,
  input  logic [TFLenWidth-1:0]                   tx_desc_len_i,
  input  logic                                    rx_desc_valid_i,
  output logic                                    rx_desc_ready_o,
  input  logic [AddrWidth-1:0]                    rx_desc_addr_i,
  input  logic [TFLenWidth-1:0]                   rx_desc_len_i,
  output logic                                    req_valid_o,
  input  logic                                    req_ready_i,
  output logic [AddrWidth-1:0]                    req_addr_o,
  output logic [TFLenWidth-1:0]                   req_len_o,
  output logic                                    req_dir_o,
  input  logic                                    rsp_valid_i,
  output logic                                    rsp_ready_o,
  input  logic                                    rsp_error_i,
  output logic                                    tx_done_o,
  output logic                                    rx_done_o,
  output logic                                    done_error_o,
  output logic                                    zero_len_err_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]     outstanding_o,
  output logic                                    busy_o,
  output logic [15:0]                             tx_frames_o,
  output logic [15:0]                             rx_frames_o,
  output logic [7:0]                              err_cnt_o
);

  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
  localparam int unsigned FifoDepth = 1 << CntWidth;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state_q, state_d;
  logic                    last_rx_q, last_rx_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [TFLenWidth-1:0]   len_q, len_d;
  logic                    dir_q, dir_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [FifoDepth-1:0]    fifo_q, fifo_d;
  logic                    tx_done_q, tx_done_d;
  logic                    rx_done_q, rx_done_d;
  logic                    done_err_q, done_err_d;
  logic                    zero_len_q, zero_len_d;
  logic [15:0]             tx_frames_q, tx_frames_d;
  logic [15:0]             rx_frames_q, rx_frames_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic                    can_grant, tx_win, tx_acc, rx_acc, push, pop;
  logic [TFLenWidth-1:0]   acc_len;
  logic [CntWidth-1:0]     push_pos;
  logic [8:0]              err_sum;

  always_comb begin
    state_d     = state_q;
    last_rx_d   = last_rx_q;
    addr_d      = addr_q;
    len_d       = len_q;
    dir_d       = dir_q;
    tx_done_d   = 1'b0;
    rx_done_d   = 1'b0;
    done_err_d  = 1'b0;
    zero_len_d  = 1'b0;
    tx_frames_d = tx_frames_q;
    rx_frames_d = rx_frames_q;

    can_grant       = (state_q == IDLE) && en_i && (cnt_q < CntWidth'(MaxOutstanding));
    tx_win          = tx_desc_valid_i && (!rx_desc_valid_i || last_rx_q);
    tx_desc_ready_o = can_grant && tx_win;
    rx_desc_ready_o = can_grant && rx_desc_valid_i && !tx_win;
    tx_acc          = tx_desc_valid_i && tx_desc_ready_o;
    rx_acc          = rx_desc_valid_i && rx_desc_ready_o;
    acc_len         = tx_acc ? tx_desc_len_i : rx_desc_len_i;

    push = (state_q == ISSUE) && req_ready_i;
    pop  = rsp_valid_i && (cnt_q != '0);

    // Shift-register FIFO: head at bit 0; a same-cycle pop moves the push slot down one.
    push_pos = cnt_q - CntWidth'(pop);
    fifo_d   = pop ? (fifo_q >> 1) : fifo_q;
    if (push) fifo_d[push_pos] = dir_q;
    cnt_d = cnt_q + CntWidth'(push) - CntWidth'(pop);

    case (state_q)
      IDLE: begin
        if (tx_acc || rx_acc) begin
          last_rx_d = rx_acc;
          if (acc_len == '0) begin
            zero_len_d = 1'b1;
          end else begin
            addr_d  = tx_acc ? tx_desc_addr_i : rx_desc_addr_i;
            len_d   = acc_len;
            dir_d   = rx_acc;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: if (req_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      tx_done_d  = !fifo_q[0];
      rx_done_d  = fifo_q[0];
      done_err_d = rsp_error_i;
      if (fifo_q[0]) rx_frames_d = rx_frames_q + 16'd1;
      else           tx_frames_d = tx_frames_q + 16'd1;
    end

    err_sum   = {1'b0, err_cnt_q} + 9'(zero_len_d) + 9'(pop && rsp_error_i);
    err_cnt_d = err_sum[8] ? '1 : err_sum[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_rx_q   <= 1'b1;
      addr_q      <= '0;
      len_q       <= '0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      fifo_q      <= '0;
      tx_done_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      done_err_q  <= 1'b0;
      zero_len_q  <= 1'b0;
      tx_frames_q <= '0;
      rx_frames_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_rx_q   <= last_rx_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
      tx_done_q   <= tx_done_d;
      rx_done_q   <= rx_done_d;
      done_err_q  <= done_err_d;
      zero_len_q  <= zero_len_d;
      tx_frames_q <= tx_frames_d;
      rx_frames_q <= rx_frames_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_valid_o    = (state_q == ISSUE);
  assign req_addr_o     = addr_q;
  assign req_len_o      = len_q;
  assign req_dir_o      = dir_q;
  assign rsp_ready_o    = (cnt_q != '0);
  assign busy_o         = (state_q == ISSUE) || (cnt_q != '0);
  assign outstanding_o  = cnt_q;
  assign tx_done_o      = tx_done_q;
  assign rx_done_o      = rx_done_q;
  assign done_error_o   = done_err_q;
  assign zero_len_err_o = zero_len_q;
  assign tx_frames_o    = tx_frames_q;
  assign rx_frames_o    = rx_frames_q;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_eth_dma_sched.sv
// Bench for eth_dma_sched: directed vector table, corner-case sequences and a
// randomized run checked against a queue-based transaction model.
module tb_eth_dma_sched;

  localparam int AW   = 64;
  localparam int LW   = 32;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk;
  logic          rst;
  logic          en_i;
  logic          tx_desc_valid_i, tx_desc_ready_o;
  logic [AW-1:0] tx_desc_addr_i;
  logic [LW-1:0] tx_desc_len_i;
  logic          rx_desc_valid_i, rx_desc_ready_o;
  logic [AW-1:0] rx_desc_addr_i;
  logic [LW-1:0] rx_desc_len_i;
  logic          req_valid_o, req_ready_i;
  logic [AW-1:0] req_addr_o;
  logic [LW-1:0] req_len_o;
  logic          req_dir_o;
  logic          rsp_valid_i, rsp_ready_o, rsp_error_i;
  logic          tx_done_o, rx_done_o, done_error_o, zero_len_err_o;
  logic [CW-1:0] outstanding_o;
  logic          busy_o;
  logic [15:0]   tx_frames_o, rx_frames_o;
  logic [7:0]    err_cnt_o;

  eth_dma_sched #(.AddrWidth(AW), .TFLenWidth(LW), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en_i),
    .tx_desc_valid_i(tx_desc_valid_i), .tx_desc_ready_o(tx_desc_ready_o),
    .tx_desc_addr_i(tx_desc_addr_i), .tx_desc_len_i(tx_desc_len_i),
    .rx_desc_valid_i(rx_desc_valid_i), .rx_desc_ready_o(rx_desc_ready_o),
    .rx_desc_addr_i(rx_desc_addr_i), .rx_desc_len_i(rx_desc_len_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_len_o(req_len_o), .req_dir_o(req_dir_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_error_i(rsp_error_i),
    .tx_done_o(tx_done_o), .rx_done_o(rx_done_o), .done_error_o(done_error_o),
    .zero_len_err_o(zero_len_err_o), .outstanding_o(outstanding_o), .busy_o(busy_o),
    .tx_frames_o(tx_frames_o), .rx_frames_o(rx_frames_o), .err_cnt_o(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_fifo[$];      // directions of issued, unanswered transfers
  bit            m_pend;         // a granted nonzero descriptor awaits its req handshake
  logic [AW-1:0] m_paddr;
  logic [LW-1:0] m_plen;
  bit            m_pdir;
  bit            m_last_rx;
  bit            m_txd, m_rxd, m_derr, m_zl;
  int            m_txf, m_rxf, m_err;
  bit            grant_q[$];
  int            req_hs;

  task automatic model_reset();
    m_fifo.delete();
    m_pend = 0; m_paddr = '0; m_plen = '0; m_pdir = 0;
    m_last_rx = 1;
    m_txd = 0; m_rxd = 0; m_derr = 0; m_zl = 0;
    m_txf = 0; m_rxf = 0; m_err = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Inputs are already driven (posedge+1); check at negedge, advance model, return at next posedge+1.
  task automatic run_cycle();
    bit can, e_txr, e_rxr, d;
    logic [LW-1:0] glen;
    @(negedge clk);
    can   = en_i && !m_pend && (m_fifo.size() < MAXO);
    e_txr = can && tx_desc_valid_i && (!rx_desc_valid_i || m_last_rx);
    e_rxr = can && rx_desc_valid_i && !e_txr;
    chk("tx_desc_ready", 64'(tx_desc_ready_o), 64'(e_txr));
    chk("rx_desc_ready", 64'(rx_desc_ready_o), 64'(e_rxr));
    chk("req_valid", 64'(req_valid_o), 64'(m_pend));
    if (m_pend) begin
      chk("req_addr", 64'(req_addr_o), 64'(m_paddr));
      chk("req_len", 64'(req_len_o), 64'(m_plen));
      chk("req_dir", 64'(req_dir_o), 64'(m_pdir));
    end
    chk("rsp_ready", 64'(rsp_ready_o), 64'(m_fifo.size() != 0));
    chk("outstanding", 64'(outstanding_o), 64'(m_fifo.size()));
    chk("busy", 64'(busy_o), 64'(m_pend || m_fifo.size() != 0));
    chk("tx_done", 64'(tx_done_o), 64'(m_txd));
    chk("rx_done", 64'(rx_done_o), 64'(m_rxd));
    chk("done_error", 64'(done_error_o), 64'(m_derr));
    chk("zero_len_err", 64'(zero_len_err_o), 64'(m_zl));
    chk("tx_frames", 64'(tx_frames_o), 64'(m_txf & 16'hFFFF));
    chk("rx_frames", 64'(rx_frames_o), 64'(m_rxf & 16'hFFFF));
    chk("err_cnt", 64'(err_cnt_o), 64'(m_err));
    if (tx_desc_valid_i && tx_desc_ready_o) grant_q.push_back(1'b0);
    if (rx_desc_valid_i && rx_desc_ready_o) grant_q.push_back(1'b1);
    if (req_valid_o && req_ready_i) req_hs++;

    m_txd = 0; m_rxd = 0; m_derr = 0; m_zl = 0;
    if (rsp_valid_i && m_fifo.size() != 0) begin
      d = m_fifo.pop_front();
      m_txd = !d; m_rxd = d; m_derr = rsp_error_i;
      if (d) m_rxf++; else m_txf++;
      if (rsp_error_i) m_err = sat_inc(m_err);
    end
    if (m_pend && req_ready_i) begin
      m_fifo.push_back(m_pdir);
      m_pend = 0;
    end
    if (e_txr || e_rxr) begin
      m_last_rx = e_rxr;
      glen = e_txr ? tx_desc_len_i : rx_desc_len_i;
      if (glen == '0) begin
        m_zl = 1;
        m_err = sat_inc(m_err);
      end else begin
        m_pend  = 1;
        m_plen  = glen;
        m_paddr = e_txr ? tx_desc_addr_i : rx_desc_addr_i;
        m_pdir  = e_rxr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en_i = 1'b1;
    tx_desc_valid_i = 1'b0; tx_desc_addr_i = '0; tx_desc_len_i = '0;
    rx_desc_valid_i = 1'b0; rx_desc_addr_i = '0; rx_desc_len_i = '0;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_error_i = 1'b0;
  endtask

  // Asserts reset off-edge, checks the asynchronous reset values, releases at posedge+1.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_req_valid", 64'(req_valid_o), 64'd0);
    chk("rst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    chk("rst_tx_ready", 64'(tx_desc_ready_o), 64'd0);
    chk("rst_rx_ready", 64'(rx_desc_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_pulses", 64'({tx_done_o, rx_done_o, done_error_o, zero_len_err_o}), 64'd0);
    chk("rst_counters", 64'({tx_frames_o, rx_frames_o, err_cnt_o}), 64'd0);
    chk("rst_req_addr", 64'(req_addr_o), 64'd0);
    chk("rst_req_len_dir", 64'({req_len_o, req_dir_o}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    tx_desc_valid_i = 1'b0; rx_desc_valid_i = 1'b0;
    en_i = 1'b1; req_ready_i = 1'b1; rsp_valid_i = 1'b1; rsp_error_i = 1'b0;
    repeat (8) run_cycle();
    rsp_valid_i = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int en, tx, rx, len, rr, rv, re;
    int e_txr, e_rxr, e_reqv, e_addr, e_dir;
    int e_txd, e_rxd, e_derr, e_zl;
    int e_out, e_err, e_txf, e_rxf;
  } vec_t;

  vec_t tbl[27];

  initial begin
    //          en tx rx len rr rv re  txr rxr reqv addr     dir  txd rxd der zl  out err txf rxf
    tbl[0]  = '{1, 1, 0, 64, 1, 0, 0,  1,  0,  0,   0,       0,   0,  0,  0,  0,  0,  0,  0,  0};
    tbl[1]  = '{1, 0, 0, 64, 1, 0, 0,  0,  0,  1,   'h1000,  0,   0,  0,  0,  0,  0,  0,  0,  0};
    tbl[2]  = '{1, 0, 0, 0,  0, 1, 0,  0,  0,  0,   0,       0,   0,  0,  0,  0,  1,  0,  0,  0};
    tbl[3]  = '{1, 0, 0, 0,  0, 0, 0,  0,  0,  0,   0,       0,   1,  0,  0,  0,  0,  0,  1,  0};
    tbl[4]  = '{1, 0, 1, 0,  0, 0, 0,  0,  1,  0,   0,       0,   0,  0,  0,  0,  0,  0,  1,  0};
    tbl[5]  = '{1, 0, 0, 0,  0, 0, 0,  0,  0,  0,   0,       0,   0,  0,  0,  1,  0,  1,  1,  0};
    tbl[6]  = '{1, 0, 1, 128,0, 0, 0,  0,  1,  0,   0,       0,   0,  0,  0,  0,  0,  1,  1,  0};
    tbl[7]  = '{1, 0, 0, 128,1, 0, 0,  0,  0,  1,   'h2000,  1,   0,  0,  0,  0,  0,  1,  1,  0};
    tbl[8]  = '{1, 0, 0, 0,  0, 1, 1,  0,  0,  0,   0,       0,   0,  0,  0,  0,  1,  1,  1,  0};
    tbl[9]  = '{1, 0, 0, 0,  0, 0, 0,  0,  0,  0,   0,       0,   0,  1,  1,  0,  0,  2,  1,  1};
    tbl[10] = '{1, 1, 0, 32, 1, 0, 0,  1,  0,  0,   0,       0,   0,  0,  0,  0,  0,  2,  1,  1};
    tbl[11] = '{1, 0, 0, 32, 1, 0, 0,  0,  0,  1,   'h1000,  0,   0,  0,  0,  0,  0,  2,  1,  1};
    tbl[12] = '{1, 0, 1, 0,  0, 1, 1,  0,  1,  0,   0,       0,   0,  0,  0,  0,  1,  2,  1,  1};
    tbl[13] = '{1, 0, 0, 0,  0, 0, 0,  0,  0,  0,   0,       0,   1,  0,  1,  1,  0,  4,  2,  1};
    tbl[14] = '{0, 1, 0, 16, 0, 0, 0,  0,  0,  0,   0,       0,   0,  0,  0,  0,  0,  4,  2,  1};
    tbl[15] = '{1, 1, 0, 16, 0, 0, 0,  1,  0,  0,   0,       0,   0,  0,  0,  0,  0,  4,  2,  1};
    tbl[16] = '{0, 0, 0, 16, 0, 0, 0,  0,  0,  1,   'h1000,  0,   0,  0,  0,  0,  0,  4,  2,  1};
    tbl[17] = '{0, 0, 0, 16, 1, 0, 0,  0,  0,  1,   'h1000,  0,   0,  0,  0,  0,  0,  4,  2,  1};
    tbl[18] = '{0, 1, 0, 0,  0, 1, 0,  0,  0,  0,   0,       0,   0,  0,  0,  0,  1,  4,  2,  1};
    tbl[19] = '{1, 0, 0, 0,  0, 0, 0,  0,  0,  0,   0,       0,   1,  0,  0,  0,  0,  4,  3,  1};
    tbl[20] = '{1, 1, 1, 8,  0, 0, 0,  0,  1,  0,   0,       0,   0,  0,  0,  0,  0,  4,  3,  1};
    tbl[21] = '{1, 0, 0, 8,  1, 0, 0,  0,  0,  1,   'h2000,  1,   0,  0,  0,  0,  0,  4,  3,  1};
    tbl[22] = '{1, 1, 1, 8,  0, 0, 0,  1,  0,  0,   0,       0,   0,  0,  0,  0,  1,  4,  3,  1};
    tbl[23] = '{1, 0, 0, 8,  1, 0, 0,  0,  0,  1,   'h1000,  0,   0,  0,  0,  0,  1,  4,  3,  1};
    tbl[24] = '{1, 0, 0, 0,  0, 1, 0,  0,  0,  0,   0,       0,   0,  0,  0,  0,  2,  4,  3,  1};
    tbl[25] = '{1, 0, 0, 0,  0, 1, 0,  0,  0,  0,   0,       0,   0,  1,  0,  0,  1,  4,  3,  2};
    tbl[26] = '{1, 0, 0, 0,  0, 0, 0,  0,  0,  0,   0,       0,   1,  0,  0,  0,  0,  4,  4,  2};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    do_reset();

    // Directed table
    for (int i = 0; i < 27; i++) begin
      en_i            = 1'(tbl[i].en);
      tx_desc_valid_i = 1'(tbl[i].tx);
      tx_desc_addr_i  = 64'h1000;
      tx_desc_len_i   = LW'(tbl[i].len);
      rx_desc_valid_i = 1'(tbl[i].rx);
      rx_desc_addr_i  = 64'h2000;
      rx_desc_len_i   = LW'(tbl[i].len);
      req_ready_i     = 1'(tbl[i].rr);
      rsp_valid_i     = 1'(tbl[i].rv);
      rsp_error_i     = 1'(tbl[i].re);
      @(negedge clk);
      chk($sformatf("v%0d_tx_ready", i), 64'(tx_desc_ready_o), 64'(tbl[i].e_txr));
      chk($sformatf("v%0d_rx_ready", i), 64'(rx_desc_ready_o), 64'(tbl[i].e_rxr));
      chk($sformatf("v%0d_req_valid", i), 64'(req_valid_o), 64'(tbl[i].e_reqv));
      if (tbl[i].e_reqv != 0) begin
        chk($sformatf("v%0d_req_addr", i), 64'(req_addr_o), 64'(tbl[i].e_addr));
        chk($sformatf("v%0d_req_len", i), 64'(req_len_o), 64'(tbl[i].len));
        chk($sformatf("v%0d_req_dir", i), 64'(req_dir_o), 64'(tbl[i].e_dir));
      end
      chk($sformatf("v%0d_pulses", i), 64'({tx_done_o, rx_done_o, done_error_o, zero_len_err_o}),
          64'({1'(tbl[i].e_txd), 1'(tbl[i].e_rxd), 1'(tbl[i].e_derr), 1'(tbl[i].e_zl)}));
      chk($sformatf("v%0d_outstanding", i), 64'(outstanding_o), 64'(tbl[i].e_out));
      chk($sformatf("v%0d_err_cnt", i), 64'(err_cnt_o), 64'(tbl[i].e_err));
      chk($sformatf("v%0d_tx_frames", i), 64'(tx_frames_o), 64'(tbl[i].e_txf));
      chk($sformatf("v%0d_rx_frames", i), 64'(rx_frames_o), 64'(tbl[i].e_rxf));
      @(posedge clk);
      #1;
    end

    // Round-robin alternation with both sides always valid
    do_reset();
    tx_desc_valid_i = 1'b1; tx_desc_addr_i = 64'h0000_0001_0000_0000; tx_desc_len_i = 32'd60;
    rx_desc_valid_i = 1'b1; rx_desc_addr_i = 64'h0000_0002_0000_0000; rx_desc_len_i = 32'd1500;
    req_ready_i = 1'b1; rsp_valid_i = 1'b1;
    grant_q.delete();
    repeat (16) run_cycle();
    tx_desc_valid_i = 1'b0; rx_desc_valid_i = 1'b0;
    repeat (4) run_cycle();
    chk("alt_grant_count", 64'(grant_q.size()), 64'd8);
    for (int k = 0; k < grant_q.size(); k++)
      chk($sformatf("alt_grant%0d", k), 64'(grant_q[k]), 64'(k % 2));
    chk("alt_tx_frames", 64'(tx_frames_o), 64'd4);
    chk("alt_rx_frames", 64'(rx_frames_o), 64'd4);

    // Outstanding limit with responses withheld
    do_reset();
    tx_desc_valid_i = 1'b1; tx_desc_addr_i = 64'h3000; tx_desc_len_i = 32'd100;
    req_ready_i = 1'b1; rsp_valid_i = 1'b0;
    req_hs = 0;
    repeat (12) run_cycle();
    chk("limit_issued", 64'(req_hs), 64'd4);
    chk("limit_outstanding", 64'(outstanding_o), 64'd4);
    chk("limit_ready_low", 64'(tx_desc_ready_o), 64'd0);
    rsp_valid_i = 1'b1;
    run_cycle();
    rsp_valid_i = 1'b0;
    chk("limit_slot_regrant", 64'(tx_desc_ready_o), 64'd1);
    run_cycle();
    chk("limit_fifth_issue", 64'(req_valid_o), 64'd1);
    drain();
    chk("limit_drained", 64'(outstanding_o), 64'd0);

    // Backend stall: request held for 10 cycles, no further grant (last grant was TX, so RX wins)
    tx_desc_valid_i = 1'b1; tx_desc_addr_i = 64'h4000; tx_desc_len_i = 32'd33;
    rx_desc_valid_i = 1'b1; rx_desc_addr_i = 64'hABC0; rx_desc_len_i = 32'd77;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0;
    run_cycle();
    for (int k = 0; k < 10; k++) begin
      chk("stall_req_valid", 64'(req_valid_o), 64'd1);
      chk("stall_req_fields", {req_addr_o[31:0], req_len_o[30:0], req_dir_o}, {32'hABC0, 31'd77, 1'b1});
      run_cycle();
    end
    drain();

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      en_i            = ($urandom_range(0, 7) != 0);
      tx_desc_valid_i = 1'($urandom);
      tx_desc_addr_i  = {$urandom, $urandom};
      tx_desc_len_i   = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 2000));
      rx_desc_valid_i = 1'($urandom);
      rx_desc_addr_i  = {$urandom, $urandom};
      rx_desc_len_i   = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 9000));
      req_ready_i     = ($urandom_range(0, 3) != 0);
      rsp_valid_i     = ($urandom_range(0, 2) != 0);
      rsp_error_i     = ($urandom_range(0, 4) == 0);
      run_cycle();
    end
    drain();

    // Error counter saturation through repeated zero-length drops
    rx_desc_valid_i = 1'b1; rx_desc_addr_i = 64'h10; rx_desc_len_i = '0;
    repeat (260) run_cycle();
    rx_desc_valid_i = 1'b0;
    run_cycle();
    chk("err_saturated", 64'(err_cnt_o), 64'd255);

    // Reset with two transfers outstanding and a request pending
    do_reset();
    tx_desc_valid_i = 1'b1; tx_desc_addr_i = 64'h5000; tx_desc_len_i = 32'd40;
    req_ready_i = 1'b1; rsp_valid_i = 1'b0;
    repeat (5) run_cycle();
    chk("pre_rst_outstanding", 64'(outstanding_o), 64'd2);
    chk("pre_rst_req_valid", 64'(req_valid_o), 64'd1);
    #2;
    do_reset();
    tx_desc_valid_i = 1'b1; tx_desc_addr_i = 64'h6000; tx_desc_len_i = 32'd40;
    req_ready_i = 1'b1;
    run_cycle();
    tx_desc_valid_i = 1'b0; rsp_valid_i = 1'b1;
    repeat (4) run_cycle();
    chk("post_rst_tx_frames", 64'(tx_frames_o), 64'd1);
    chk("post_rst_outstanding", 64'(outstanding_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_dma_sched.md
# eth_dma_sched

Scheduler that shares the single Ethernet iDMA backend between the TX path (memory to AXIS, frame to MAC) and the RX path (AXIS to memory, frame from MAC). It accepts per-frame TX and RX descriptors and arbitrates between them round-robin. It issues one 1D transfer request per frame to the backend, limits in-flight transfers, and routes in-order backend responses back as per-direction completion pulses with frame and error counters. It sits between the descriptor/register front end and the backend request/response ports, in the iDMA clock domain.

## Interface
- AddrWidth, 64, descriptor buffer address width
- TFLenWidth, 32, transfer length width in bytes
- MaxOutstanding, 4, max issued-but-uncompleted transfers (1..16)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  scheduler enable; low blocks new grants only
- tx_desc_valid_i / tx_desc_ready_o  in/out  1  TX descriptor handshake
- tx_desc_addr_i  in  AddrWidth  TX source buffer address
- tx_desc_len_i  in  TFLenWidth  TX frame length in bytes
- rx_desc_valid_i / rx_desc_ready_o  in/out  1  RX descriptor handshake
- rx_desc_addr_i  in  AddrWidth  RX destination buffer address
- rx_desc_len_i  in  TFLenWidth  RX buffer length in bytes
- req_valid_o / req_ready_i  out/in  1  backend request handshake
- req_addr_o  out  AddrWidth  memory-side address
- req_len_o  out  TFLenWidth  transfer length
- req_dir_o  out  1  0 = TX (AXI read to AXIS), 1 = RX (AXIS to AXI write)
- rsp_valid_i / rsp_ready_o  in/out  1  backend response handshake
- rsp_error_i  in  1  backend reported error for this transfer
- tx_done_o, rx_done_o  out  1  one-cycle completion pulses
- done_error_o  out  1  error flag, qualifies the done pulse of the same cycle
- zero_len_err_o  out  1  one-cycle pulse; zero-length descriptor dropped
- outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight count
- busy_o  out  1  request pending or outstanding_o != 0
- tx_frames_o, rx_frames_o  out  16  completed frame counters, wrapping
- err_cnt_o  out  8  error counter (rsp errors + zero-length drops), saturating at 255

## Operation
- FSM states:
  - IDLE: the scheduler may grant one descriptor.
  - ISSUE: req_valid_o is held high with fields registered and stable until req_ready_i; then it returns to IDLE.
- Grant condition in IDLE: en_i high and outstanding_o < MaxOutstanding. The ready goes to one requester combinationally:
  - Only one side is valid: grant that side.
  - Both are valid: grant the side not granted last. The last-grant flag resets to RX, so TX wins the first tie.
  - A descriptor is accepted only when its valid and ready are both high.
- Accepted descriptor with len == 0: not issued; zero_len_err_o pulses and err_cnt_o increments on the next cycle; FSM stays IDLE. The last-grant flag still updates.
- Accepted nonzero descriptor: load the address, length and direction registers, then go to ISSUE.
- On the req handshake, push req_dir_o into the direction FIFO (depth MaxOutstanding) and increment outstanding_o.
- rsp_ready_o = FIFO not empty. On a rsp handshake, pop the FIFO and decrement outstanding_o. On the next cycle:
  - pulse tx_done_o or rx_done_o according to the popped direction;
  - drive done_error_o = rsp_error_i;
  - increment the matching frame counter (also on error);
  - increment err_cnt_o on error.
- Push and pop in the same cycle: outstanding_o and the FIFO level are unchanged, both operations take effect.
- Zero-length drop and rsp error in the same cycle: err_cnt_o += 2 (saturating).
- en_i falling while in ISSUE: the pending request still completes, and responses are still collected.

## Timing
- Reset values:
  - all counters 0, outstanding_o 0, FSM IDLE, FIFO empty;
  - req_valid_o, rsp_ready_o, both desc_ready, all pulses and busy_o = 0;
  - req_addr_o, req_len_o, req_dir_o = 0.
- Reset mid-operation discards all state, including in-flight bookkeeping.
- Latency:
  - Descriptor accepted in cycle N gives req_valid_o high in cycle N+1.
  - The earliest next grant is the cycle after the req handshake.
  - The completion pulse comes one cycle after the rsp handshake.
- Throughput: at most one request every 2 cycles.
- desc_ready outputs are low throughout ISSUE, while en_i is low, and while outstanding_o == MaxOutstanding.
- A slot freed by a response in cycle N is grantable in cycle N+1.

## Test plan
- Single TX desc (addr 0x1000, len 64), req_ready_i tied 1:
  - req_valid_o one cycle later with addr 0x1000, len 64, dir 0;
  - rsp one cycle later gives tx_done_o pulse, tx_frames_o = 1, outstanding_o back to 0.
- TX and RX valid continuously, backend always ready and responding: grants alternate TX, RX, TX, RX; after 8 responses tx_frames_o = rx_frames_o = 4.
- Responses withheld, MaxOutstanding = 4, 6 descriptors offered:
  - exactly 4 requests are issued, outstanding_o = 4, desc_ready stays low;
  - one response then allows a 5th grant in the following cycle.
- req_ready_i held low for 10 cycles: req_valid_o stays high and all fields stay constant; no second grant occurs.
- RX desc with len 0: no request issued; zero_len_err_o pulses and err_cnt_o = 1. rsp_error_i on the next transfer gives done_error_o with the done pulse and err_cnt_o = 2.
- rst_i asserted with 2 outstanding and ISSUE pending: all outputs return to reset values asynchronously; after release, a new TX desc issues normally.
